// File: rtl/ecc_pkg.sv
// Shared types and the point-doubling microprogram for the ECC engines.
package ecc_pkg;

  localparam int unsigned NUM_STEPS = 30;
  localparam int unsigned STEP_W    = 5;

  typedef enum logic [1:0] {OP_MUL, OP_ADD, OP_SUB} op_e;

  typedef enum logic [3:0] {
    R_X, R_Y, R_Z, R_AM, R_T1, R_T2, R_T3, R_R2, R_ONE
  } reg_e;

  typedef enum logic [1:0] {StIdle, StRun, StInf, StDone} state_e;

  typedef struct packed {
    op_e  op;
    reg_e src_a;
    reg_e src_b;
    reg_e dst;
  } uop_t;

  // Jacobian doubling: enter Montgomery domain, M/S/8Y^4, X3/Y3/Z3, leave domain.
  function automatic uop_t ucode(input logic [STEP_W-1:0] step);
    uop_t u;
    u = '{OP_MUL, R_X, R_ONE, R_X};
    case (step)
      5'd1:  u = '{OP_MUL, R_X,  R_R2,  R_X};
      5'd2:  u = '{OP_MUL, R_Y,  R_R2,  R_Y};
      5'd3:  u = '{OP_MUL, R_Z,  R_R2,  R_Z};
      5'd4:  u = '{OP_MUL, R_AM, R_R2,  R_AM};
      5'd5:  u = '{OP_MUL, R_X,  R_X,   R_T1};
      5'd6:  u = '{OP_MUL, R_Z,  R_Z,   R_T2};
      5'd7:  u = '{OP_MUL, R_T2, R_T2,  R_T2};
      5'd8:  u = '{OP_MUL, R_AM, R_T2,  R_T2};
      5'd9:  u = '{OP_ADD, R_T1, R_T1,  R_T3};
      5'd10: u = '{OP_ADD, R_T3, R_T1,  R_T1};
      5'd11: u = '{OP_ADD, R_T1, R_T2,  R_T1};
      5'd12: u = '{OP_MUL, R_Y,  R_Y,   R_T2};
      5'd13: u = '{OP_MUL, R_X,  R_T2,  R_T3};
      5'd14: u = '{OP_ADD, R_T3, R_T3,  R_T3};
      5'd15: u = '{OP_ADD, R_T3, R_T3,  R_T3};
      5'd16: u = '{OP_MUL, R_T2, R_T2,  R_T2};
      5'd17: u = '{OP_ADD, R_T2, R_T2,  R_T2};
      5'd18: u = '{OP_ADD, R_T2, R_T2,  R_T2};
      5'd19: u = '{OP_ADD, R_T2, R_T2,  R_T2};
      5'd20: u = '{OP_MUL, R_Y,  R_Z,   R_Z};
      5'd21: u = '{OP_ADD, R_Z,  R_Z,   R_Z};
      5'd22: u = '{OP_MUL, R_T1, R_T1,  R_X};
      5'd23: u = '{OP_SUB, R_X,  R_T3,  R_X};
      5'd24: u = '{OP_SUB, R_X,  R_T3,  R_X};
      5'd25: u = '{OP_SUB, R_T3, R_X,   R_T3};
      5'd26: u = '{OP_MUL, R_T1, R_T3,  R_T3};
      5'd27: u = '{OP_SUB, R_T3, R_T2,  R_Y};
      5'd28: u = '{OP_MUL, R_X,  R_ONE, R_X};
      5'd29: u = '{OP_MUL, R_Y,  R_ONE, R_Y};
      5'd30: u = '{OP_MUL, R_Z,  R_ONE, R_Z};
      default: ;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/point_double_seq_if.sv
// Request/response bundle between the scalar-mult controller and the doubler.
interface point_double_seq_if #(
  parameter int unsigned LEN = 256
);
  logic           start;
  logic [LEN-1:0] a;
  logic [LEN-1:0] p;
  logic [LEN-1:0] p_prime;
  logic [LEN-1:0] r2_mod_p;
  logic [LEN-1:0] px;
  logic [LEN-1:0] py;
  logic [LEN-1:0] pz;
  logic           busy;
  logic           done;
  logic [LEN-1:0] rx;
  logic [LEN-1:0] ry;
  logic [LEN-1:0] rz;

  modport master (
    output start, a, p, p_prime, r2_mod_p, px, py, pz,
    input  busy, done, rx, ry, rz
  );

  modport slave (
    input  start, a, p, p_prime, r2_mod_p, px, py, pz,
    output busy, done, rx, ry, rz
  );
endinterface

// File: rtl/field_alu.sv
// Combinational GF(p) ALU: Montgomery multiply, modular add and subtract.
module field_alu
  import ecc_pkg::*;
#(
  parameter int unsigned LEN = 256
) (
  input  op_e            op,
  input  logic [LEN-1:0] opa,
  input  logic [LEN-1:0] opb,
  input  logic [LEN-1:0] p,
  input  logic [LEN-1:0] p_prime,
  output logic [LEN-1:0] res
);

  logic [2*LEN-1:0] prod;
  logic [2*LEN-1:0] mp;
  logic [LEN-1:0]   m;
  logic [2*LEN:0]   acc;
  logic [LEN:0]     u;
  logic [LEN:0]     s;
  logic [LEN:0]     d;
  logic             unused_acc_low;

  always_comb begin
    prod = {{LEN{1'b0}}, opa} * {{LEN{1'b0}}, opb};
    m    = prod[LEN-1:0] * p_prime;
    mp   = {{LEN{1'b0}}, m} * {{LEN{1'b0}}, p};
    // Low half is zero by construction of m; the quotient is < 2p.
    acc  = {1'b0, prod} + {1'b0, mp};
    u    = acc[2*LEN:LEN];
    s    = {1'b0, opa} + {1'b0, opb};
    d    = {1'b0, opa} - {1'b0, opb};
    res  = '0;
    case (op)
      OP_MUL:  res = (u >= {1'b0, p}) ? LEN'(u - {1'b0, p}) : u[LEN-1:0];
      OP_ADD:  res = (s >= {1'b0, p}) ? LEN'(s - {1'b0, p}) : s[LEN-1:0];
      OP_SUB:  res = d[LEN] ? LEN'(d[LEN-1:0] + p) : d[LEN-1:0];
      default: res = '0;
    endcase
  end

  assign unused_acc_low = ^acc[LEN-1:0];

endmodule

// File: rtl/point_double_seq.sv
// Microcoded Jacobian point doubler: one shared field ALU op per cycle.
module point_double_seq
  import ecc_pkg::*;
#(
  parameter int unsigned LEN = 256
) (
  input logic               clk,
  input logic               rst_n,
  point_double_seq_if.slave bus
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [LEN-1:0]      x_q, x_d, y_q, y_d, z_q, z_d, am_q, am_d;
  logic [LEN-1:0]      t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
  logic [LEN-1:0]      p_q, p_d, pp_q, pp_d, r2_q, r2_d;
  logic [LEN-1:0]      rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
  logic [LEN-1:0]      alu_a, alu_b, alu_res;
  uop_t                uop;

  function automatic logic [LEN-1:0] pick(input reg_e sel);
    case (sel)
      R_X:     return x_q;
      R_Y:     return y_q;
      R_Z:     return z_q;
      R_AM:    return am_q;
      R_T1:    return t1_q;
      R_T2:    return t2_q;
      R_T3:    return t3_q;
      R_R2:    return r2_q;
      R_ONE:   return LEN'(1);
      default: return '0;
    endcase
  endfunction

  assign uop   = ucode(step_q);
  assign alu_a = pick(uop.src_a);
  assign alu_b = pick(uop.src_b);

  field_alu #(.LEN(LEN)) u_alu (
    .op      (uop.op),
    .opa     (alu_a),
    .opb     (alu_b),
    .p       (p_q),
    .p_prime (pp_q),
    .res     (alu_res)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_d  = x_q;  y_d  = y_q;  z_d  = z_q;  am_d = am_q;
    t1_d = t1_q; t2_d = t2_q; t3_d = t3_q;
    p_d  = p_q;  pp_d = pp_q; r2_d = r2_q;
    rx_d = rx_q; ry_d = ry_q; rz_d = rz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          x_d     = bus.px;
          y_d     = bus.py;
          z_d     = bus.pz;
          am_d    = bus.a;
          p_d     = bus.p;
          pp_d    = bus.p_prime;
          r2_d    = bus.r2_mod_p;
          step_d  = STEP_W'(1);
          state_d = (bus.pz == '0) ? StInf : StRun;
        end
      end
      StRun: begin
        case (uop.dst)
          R_X:     x_d  = alu_res;
          R_Y:     y_d  = alu_res;
          R_Z:     z_d  = alu_res;
          R_AM:    am_d = alu_res;
          R_T1:    t1_d = alu_res;
          R_T2:    t2_d = alu_res;
          R_T3:    t3_d = alu_res;
          default: ;
        endcase
        if (step_q == STEP_W'(NUM_STEPS)) begin
          // Last step converts z, so its result bypasses the z register.
          rx_d    = x_q;
          ry_d    = y_q;
          rz_d    = alu_res;
          state_d = StDone;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      StInf: begin
        rx_d    = LEN'(1);
        ry_d    = LEN'(1);
        rz_d    = '0;
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= '0;
      x_q  <= '0; y_q  <= '0; z_q  <= '0; am_q <= '0;
      t1_q <= '0; t2_q <= '0; t3_q <= '0;
      p_q  <= '0; pp_q <= '0; r2_q <= '0;
      rx_q <= '0; ry_q <= '0; rz_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      x_q  <= x_d;  y_q  <= y_d;  z_q  <= z_d;  am_q <= am_d;
      t1_q <= t1_d; t2_q <= t2_d; t3_q <= t3_d;
      p_q  <= p_d;  pp_q <= pp_d; r2_q <= r2_d;
      rx_q <= rx_d; ry_q <= ry_d; rz_q <= rz_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.rx   = rx_q;
  assign bus.ry   = ry_q;
  assign bus.rz   = rz_q;

endmodule
